// File: rtl/spi_node_shifter_pkg.sv
// Shared types and SPI mode helpers for the node-side serial engine.
package spi_node_shifter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } node_state_e;

  // Leading edge is the first sclk transition away from the idle level.
  function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

  // Trailing edge returns sclk to its idle level.
  function automatic logic trail_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? rise : fall;
  endfunction

  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
  function automatic logic sample_edge(input logic cpha, input logic lead, input logic trail);
    return cpha ? trail : lead;
  endfunction

  // The drive edge is always the edge that does not sample.
  function automatic logic drive_edge(input logic cpha, input logic lead, input logic trail);
    return cpha ? lead : trail;
  endfunction

endpackage

// File: rtl/spi_node_shifter_edge_sync.sv
// Multi-flop synchroniser for one asynchronous pin, followed by an
// edge-detect flop producing single-cycle rise/fall pulses.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchroniser chain and remember the last settled level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Reset to the pin's idle level so leaving reset never fakes an edge.
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_node_shifter.sv
// SPI node-side serial engine: oversamples sclk/mosi/sel on clk, shifts
// MSB-first full duplex, one tx holding register, rx word as a 1-cycle pulse.
module spi_node_shifter
  import spi_node_shifter_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  sel,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Synchronised pin events
  logic sclk_rise, sclk_fall, sel_rise, sel_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s, lead, trail, sample_ev, drive_ev;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .rst(rst), .d_i(sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sel_sync (
    .clk(clk), .rst(rst), .d_i(sel), .rise_o(sel_rise), .fall_o(sel_fall)
  );

  // Same depth as the sclk chain so mosi is seen at the age it had on the sclk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign lead      = lead_edge(CPOL, sclk_rise, sclk_fall);
  assign trail     = trail_edge(CPOL, sclk_rise, sclk_fall);
  assign sample_ev = sample_edge(CPHA, lead, trail);
  assign drive_ev  = drive_edge(CPHA, lead, trail);

  // State
  node_state_e           state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_buf_full_q, tx_buf_full_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  frame_err_q, frame_err_d;
  logic                  skip_q, skip_d;      // CPHA=1: hold MSB over first drive edge
  logic                  restart_q, restart_d; // CPHA=0: next drive edge starts a frame
  logic                  frame_start;
  logic [DATA_WIDTH-1:0] rx_shift;

  assign rx_shift = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};

  // Register all state; every flop takes its next value from the comb block below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      tx_buf_q      <= '0;
      tx_buf_full_q <= 1'b0;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      skip_q        <= 1'b0;
      restart_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_buf_q      <= tx_buf_d;
      tx_buf_full_q <= tx_buf_full_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      underrun_q    <= underrun_d;
      frame_err_q   <= frame_err_d;
      skip_q        <= skip_d;
      restart_q     <= restart_d;
    end
  end

  // Next-state: FSM, shifting on sample/drive edges, frame start and tx buffer load.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_buf_d      = tx_buf_q;
    tx_buf_full_d = tx_buf_full_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    underrun_d    = 1'b0;
    frame_err_d   = 1'b0;
    skip_d        = skip_q;
    restart_d     = restart_q;
    frame_start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // sclk edges are ignored here, including one coinciding with the sel rise.
        if (sel_rise) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (sel_fall) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          frame_err_d = (bit_cnt_q != '0);
          skip_d      = 1'b0;
          restart_d   = 1'b0;
        end else begin
          if (sample_ev) begin
            rx_sr_d = rx_shift;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d  = rx_shift;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              if (CPHA) frame_start = 1'b1;
              else      restart_d   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (drive_ev) begin
            if (restart_q) begin
              frame_start = 1'b1;
              restart_d   = 1'b0;
            end else if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A started frame consumes the buffer (or zeros when empty).
    if (frame_start) begin
      tx_sr_d       = tx_buf_full_q ? tx_buf_q : '0;
      underrun_d    = ~tx_buf_full_q;
      tx_buf_full_d = 1'b0;
      skip_d        = CPHA;
    end

    // Capture after the frame start so a same-cycle load is kept for the next frame.
    if (tx_valid && !tx_buf_full_q) begin
      tx_buf_d      = tx_data;
      tx_buf_full_d = 1'b1;
    end
  end

  assign miso_oe     = (state_q == ACTIVE);
  assign busy        = (state_q == ACTIVE);
  assign miso        = (state_q == ACTIVE) & tx_sr_q[DATA_WIDTH-1];
  assign tx_ready    = ~tx_buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_node_shifter.sv
// Directed bench: one node instance per SPI mode (index = {CPOL,CPHA}),
// the bench plays spi_main on each instance's pins.
module tb_spi_node_shifter;

  localparam int W    = 8;
  localparam int HALF = 8; // clk cycles per sclk half-period

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sclk_p   [4];
  logic         mosi_p   [4];
  logic         sel_p    [4];
  logic [W-1:0] tx_data_p[4];
  logic         tx_valid_p[4];
  logic         miso_w   [4];
  logic         miso_oe_w[4];
  logic         tx_ready_w[4];
  logic [W-1:0] rx_data_w[4];
  logic         rx_valid_w[4];
  logic         underrun_w[4];
  logic         frame_err_w[4];
  logic         busy_w   [4];

  int           rx_cnt  [4] = '{default: 0};
  int           ur_cnt  [4] = '{default: 0};
  int           fe_cnt  [4] = '{default: 0};
  logic [W-1:0] rx_last [4] = '{default: '0};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_node_shifter #(
      .DATA_WIDTH(W), .CPOL((g / 2) == 1), .CPHA((g % 2) == 1), .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk), .rst(rst),
      .sclk(sclk_p[g]), .mosi(mosi_p[g]), .sel(sel_p[g]),
      .miso(miso_w[g]), .miso_oe(miso_oe_w[g]),
      .tx_data(tx_data_p[g]), .tx_valid(tx_valid_p[g]), .tx_ready(tx_ready_w[g]),
      .rx_data(rx_data_w[g]), .rx_valid(rx_valid_w[g]),
      .tx_underrun(underrun_w[g]), .frame_err(frame_err_w[g]), .busy(busy_w[g])
    );

    // Pulse monitors
    always @(posedge clk) begin
      if (rx_valid_w[g]) begin
        rx_cnt[g]  <= rx_cnt[g] + 1;
        rx_last[g] <= rx_data_w[g];
      end
      if (underrun_w[g])  ur_cnt[g] <= ur_cnt[g] + 1;
      if (frame_err_w[g]) fe_cnt[g] <= fe_cnt[g] + 1;
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic half_period();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic load(input int m, input logic [W-1:0] d);
    int k;
    @(negedge clk);
    tx_data_p[m]  = d;
    tx_valid_p[m] = 1'b1;
    k = 0;
    while (!tx_ready_w[m] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("load_ready_timeout", 32'(tx_ready_w[m]), 32'd1);
    @(negedge clk);
    tx_valid_p[m] = 1'b0;
  endtask

  task automatic sel_on(input int m);
    @(negedge clk);
    sel_p[m] = 1'b1;
    half_period();
  endtask

  task automatic sel_off(input int m);
    half_period();
    sel_p[m] = 1'b0;
    half_period();
  endtask

  // Main side of a transfer: shifts out mo MSB-first, samples miso into mi.
  task automatic xfer(input int m, input logic [W-1:0] mo, input int nbits,
                      output logic [W-1:0] mi);
    logic cpol, cpha;
    cpol = ((m >> 1) & 1) == 1;
    cpha = (m & 1) == 1;
    mi = '0;
    for (int i = W - 1; i >= W - nbits; i--) begin
      if (!cpha) begin
        mosi_p[m] = mo[i];
        half_period();
        sclk_p[m] = ~cpol;
        mi[i] = miso_w[m];
        half_period();
        sclk_p[m] = cpol;
      end else begin
        sclk_p[m] = ~cpol;
        mosi_p[m] = mo[i];
        half_period();
        mi[i] = miso_w[m];
        sclk_p[m] = cpol;
        half_period();
      end
    end
  endtask

  initial begin
    logic [W-1:0] mi;
    int r0, u0, f0;

    for (int m = 0; m < 4; m++) begin
      sclk_p[m]     = ((m >> 1) & 1) == 1;
      mosi_p[m]     = 1'b0;
      sel_p[m]      = 1'b0;
      tx_data_p[m]  = '0;
      tx_valid_p[m] = 1'b0;
    end
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_miso_oe", 32'(miso_oe_w[0]), 32'd0);
    check("rst_tx_ready", 32'(tx_ready_w[0]), 32'd1);
    check("rst_rx_data", 32'(rx_data_w[0]), 32'h00);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Mode 0 exchange: node 0xA5, main 0x3C
    load(0, 8'hA5);
    check("m0_tx_ready_full", 32'(tx_ready_w[0]), 32'd0);
    r0 = rx_cnt[0];
    sel_on(0);
    check("m0_tx_ready_after_start", 32'(tx_ready_w[0]), 32'd1);
    xfer(0, 8'h3C, W, mi);
    sel_off(0);
    check("m0_miso", 32'(mi), 32'hA5);
    check("m0_rx_data", 32'(rx_last[0]), 32'h3C);
    check("m0_rx_count", 32'(rx_cnt[0] - r0), 32'd1);

    // Modes 1..3 exchange: node 0x5A, main 0xC3
    for (int m = 1; m < 4; m++) begin
      load(m, 8'h5A);
      r0 = rx_cnt[m];
      sel_on(m);
      xfer(m, 8'hC3, W, mi);
      sel_off(m);
      check($sformatf("m%0d_miso", m), 32'(mi), 32'h5A);
      check($sformatf("m%0d_rx_data", m), 32'(rx_last[m]), 32'hC3);
      check($sformatf("m%0d_rx_count", m), 32'(rx_cnt[m] - r0), 32'd1);
    end

    // Back-to-back mode 0, sel held: 0x11 then 0x22 (0x33 queued so no frame starts empty)
    u0 = ur_cnt[0];
    r0 = rx_cnt[0];
    load(0, 8'h11);
    sel_on(0);
    load(0, 8'h22);
    xfer(0, 8'h81, W, mi);
    check("b2b_miso1", 32'(mi), 32'h11);
    load(0, 8'h33);
    repeat (2) @(negedge clk);
    check("b2b_rx1", 32'(rx_last[0]), 32'h81);
    xfer(0, 8'h7E, W, mi);
    sel_off(0);
    check("b2b_miso2", 32'(mi), 32'h22);
    check("b2b_rx2", 32'(rx_last[0]), 32'h7E);
    check("b2b_rx_count", 32'(rx_cnt[0] - r0), 32'd2);
    check("b2b_no_underrun", 32'(ur_cnt[0] - u0), 32'd0);

    // Underrun: no word loaded, main sends 0x96
    u0 = ur_cnt[0];
    sel_on(0);
    check("ur_pulse_at_start", 32'(ur_cnt[0] - u0), 32'd1);
    xfer(0, 8'h96, W, mi);
    sel_off(0);
    check("ur_miso_zero", 32'(mi), 32'h00);
    check("ur_rx_data", 32'(rx_last[0]), 32'h96);

    // Frame error: sel dropped after 3 bits, then a clean frame
    f0 = fe_cnt[0];
    r0 = rx_cnt[0];
    load(0, 8'hF0);
    sel_on(0);
    xfer(0, 8'hFF, 3, mi);
    sel_off(0);
    check("fe_pulse", 32'(fe_cnt[0] - f0), 32'd1);
    check("fe_no_rx", 32'(rx_cnt[0] - r0), 32'd0);
    check("fe_miso_oe", 32'(miso_oe_w[0]), 32'd0);
    load(0, 8'h3C);
    sel_on(0);
    xfer(0, 8'h69, W, mi);
    sel_off(0);
    check("fe_next_miso", 32'(mi), 32'h3C);
    check("fe_next_rx", 32'(rx_last[0]), 32'h69);

    // Reset mid-frame on mode 3
    load(3, 8'h77);
    sel_on(3);
    xfer(3, 8'hAA, 4, mi);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_miso_oe", 32'(miso_oe_w[3]), 32'd0);
    check("rst_mid_miso", 32'(miso_w[3]), 32'd0);
    check("rst_mid_busy", 32'(busy_w[3]), 32'd0);
    check("rst_mid_tx_ready", 32'(tx_ready_w[3]), 32'd1);
    check("rst_mid_rx_data", 32'(rx_data_w[3]), 32'h00);
    sel_p[3]  = 1'b0;
    sclk_p[3] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    u0 = ur_cnt[3];
    load(3, 8'h5A);
    sel_on(3);
    check("post_rst_no_underrun", 32'(ur_cnt[3] - u0), 32'd0);
    xfer(3, 8'hC3, W, mi);
    sel_off(3);
    check("post_rst_miso", 32'(mi), 32'h5A);
    check("post_rst_rx", 32'(rx_last[3]), 32'hC3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
